// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and defaults for the external data memory model
//
// Purpose : state encoding for the responder FSM, default bus widths and the
//           byte-offset width of one cache line.
// Ports   : none (package).
package mem_pkg;

    localparam int MEM_LINE_W     = 256;
    localparam int MEM_ADDR_W     = 32;
    // log2 of the line size in bytes (32 bytes per 256-bit line)
    localparam int MEM_LINE_OFF_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } mem_state_e;

endpackage

// File: rtl/line_ram.sv
// rtl/line_ram.sv - single-port line storage with synchronous write and registered read
//
// Purpose : DEPTH x LINE_W array. One access per enabled edge: write stores
//           wdata_i, read loads the line into the output register. The output
//           register holds its value between reads and clears on reset; the
//           array itself is never cleared.
// Ports   : clk      - clock, rising edge
//           rst_n    - asynchronous active-low reset (output register only)
//           en_i     - access enable
//           we_i     - 1 = write, 0 = read
//           idx_i    - line index
//           wdata_i  - write line
//           rdata_o  - last line read
module line_ram #(
    parameter int LINE_W = 256,
    parameter int DEPTH  = 512,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic [LINE_W-1:0] rdata_o
);

    logic [LINE_W-1:0] mem_q [DEPTH];
    logic [LINE_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ext_data_memory.sv
// rtl/ext_data_memory.sv - fixed-latency off-chip line memory responder
//
// Purpose : responder end of the cache line-fill / write-back bus. A request
//           sampled in IDLE is latched, the memory waits LATENCY edges, performs
//           the access on the edge entering ACK and pulses ack_o for one cycle.
// Ports   : clk    - clock, rising edge
//           rst_n  - asynchronous active-low reset
//           addr_i - byte address; line index = addr_i[5 +: log2(DEPTH)]
//           cs_i   - request valid (sampled in IDLE only)
//           we_i   - 1 = write line, 0 = read line
//           data_i - write line
//           data_o - read line, meaningful while ack_o = 1
//           ack_o  - one-cycle transaction-done pulse
module ext_data_memory
    import mem_pkg::*;
#(
    parameter int LINE_W  = MEM_LINE_W,
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DEPTH   = 512,
    parameter int LATENCY = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              cs_i,
    input  logic              we_i,
    input  logic [LINE_W-1:0] data_i,
    output logic [LINE_W-1:0] data_o,
    output logic              ack_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              we_q, we_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              ram_en;

    // Byte offset and index bits beyond DEPTH are deliberately dropped, so
    // addresses wrap modulo DEPTH lines.
    logic unused_addr;
    assign unused_addr = ^{addr_i[MEM_LINE_OFF_W-1:0], addr_i[ADDR_W-1:MEM_LINE_OFF_W+IDX_W]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        ram_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cs_i) begin
                    idx_d   = addr_i[MEM_LINE_OFF_W +: IDX_W];
                    we_d    = we_i;
                    wdata_d = data_i;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Bus inputs are ignored here; the request is already latched.
                if (cnt_q == '0) begin
                    ram_en  = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    assign ack_o = (state_q == ST_ACK);

    // The RAM read register is data_o: it loads on the edge entering ACK for
    // reads and keeps its previous value across writes and idle cycles.
    line_ram #(
        .LINE_W (LINE_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_line_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (ram_en),
        .we_i    (we_q),
        .idx_i   (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (data_o)
    );

endmodule

// File: tb/tb_ext_data_memory.sv
// tb/tb_ext_data_memory.sv - self-checking bench for ext_data_memory
module tb_ext_data_memory;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  addr;
    logic         we;
    logic [255:0] wdata;
    logic         cs0, cs1;
    logic [255:0] dout0, dout1;
    logic         ack0, ack1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ext_data_memory #(.LATENCY(10)) dut0 (
        .clk(clk), .rst_n(rst_n), .addr_i(addr), .cs_i(cs0), .we_i(we),
        .data_i(wdata), .data_o(dout0), .ack_o(ack0)
    );

    ext_data_memory #(.LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .addr_i(addr), .cs_i(cs1), .we_i(we),
        .data_i(wdata), .data_o(dout1), .ack_o(ack1)
    );

    typedef struct {
        logic         w;
        logic [31:0]  a;
        logic [255:0] d;
        logic [255:0] exp_d;
        int           exp_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Issue one request on dut0 (sel=0) or dut1 (sel=1). lat = edges from the
    // sampling edge to the first cycle with ack high (40 means timed out).
    task automatic xact(input bit sel, input logic w, input logic [31:0] a,
                        input logic [255:0] d, input bit hold,
                        output int lat, output logic [255:0] rd);
        @(posedge clk); #1;
        addr = a; we = w; wdata = d;
        if (sel) cs1 = 1'b1; else cs0 = 1'b1;
        @(posedge clk); #1;
        if (!hold) begin
            cs0 = 1'b0; cs1 = 1'b0;
            addr = ~a; we = ~w; wdata = ~d;
        end
        lat = 0;
        rd  = '0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if ((sel ? ack1 : ack0) === 1'b1) break;
        end
        rd = sel ? dout1 : dout0;
    endtask

    initial begin
        int lat, n;
        logic [255:0] rd;
        logic seen;

        rst_n = 1'b0; cs0 = 1'b0; cs1 = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ack0", {255'b0, ack0}, 256'd0);
        check("reset_dout0", dout0, 256'd0);
        check("reset_ack1", {255'b0, ack1}, 256'd0);
        check("reset_dout1", dout1, 256'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Writes expect data_o to still hold the previous read value.
        vecs[0] = '{1'b1, 32'h0000_0040, {32{8'hA5}}, 256'd0,         10};
        vecs[1] = '{1'b0, 32'h0000_0040, 256'd0,       {32{8'hA5}},   10};
        vecs[2] = '{1'b1, 32'h0000_0020, 256'h1,       {32{8'hA5}},   10};
        vecs[3] = '{1'b0, 32'h0000_403F, 256'd0,       256'h1,        10};
        vecs[4] = '{1'b1, 32'h0000_0080, 256'hBEEF,    256'h1,        10};
        vecs[5] = '{1'b0, 32'h0000_0080, 256'd0,       256'hBEEF,     10};
        vecs[6] = '{1'b1, 32'h0000_0100, 256'h1234,    256'hBEEF,     10};
        vecs[7] = '{1'b0, 32'h0000_0100, 256'd0,       256'h1234,     10};
        vecs[8] = '{1'b1, 32'h0000_4040, {32{8'hC3}},  256'h1234,     10};
        vecs[9] = '{1'b0, 32'h0000_0040, 256'd0,       {32{8'hC3}},   10};

        for (int i = 0; i < 10; i++) begin
            xact(1'b0, vecs[i].w, vecs[i].a, vecs[i].d, 1'b0, lat, rd);
            check($sformatf("vec%0d_lat", i), 256'(lat), 256'(vecs[i].exp_lat));
            check($sformatf("vec%0d_data", i), rd, vecs[i].exp_d);
            @(negedge clk);
            check($sformatf("vec%0d_ack_low", i), {255'b0, ack0}, 256'd0);
        end

        // cs held through ack: repeat access LATENCY+2 cycles after the first ack
        xact(1'b0, 1'b0, 32'h0000_0020, 256'd0, 1'b1, lat, rd);
        check("held_lat", 256'(lat), 256'd10);
        check("held_data", rd, 256'h1);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (ack0 === 1'b1) break;
        end
        cs0 = 1'b0;
        check("held_second_ack", 256'(n), 256'd12);
        check("held_second_data", dout0, 256'h1);
        @(negedge clk);
        check("held_ack_low", {255'b0, ack0}, 256'd0);

        // asynchronous reset while ack and data_o are active
        xact(1'b0, 1'b0, 32'h0000_0080, 256'd0, 1'b0, lat, rd);
        check("pre_rst_data", rd, 256'hBEEF);
        rst_n = 1'b0;
        #1;
        check("async_rst_ack", {255'b0, ack0}, 256'd0);
        check("async_rst_data", dout0, 256'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // reset mid-WAIT drops a pending write
        @(posedge clk); #1;
        addr = 32'h0000_0100; we = 1'b1; wdata = 256'hFF; cs0 = 1'b1;
        @(posedge clk); #1 cs0 = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen |= ack0;
        end
        rst_n = 1'b1;
        repeat (15) begin
            @(negedge clk);
            seen |= ack0;
        end
        check("rst_wait_no_ack", {255'b0, seen}, 256'd0);
        xact(1'b0, 1'b0, 32'h0000_0100, 256'd0, 1'b0, lat, rd);
        check("rst_wait_lat", 256'(lat), 256'd10);
        check("rst_wait_data", rd, 256'h1234);

        // LATENCY = 1 instance
        xact(1'b1, 1'b1, 32'h0000_0040, {32{8'h5A}}, 1'b0, lat, rd);
        check("lat1_wr_lat", 256'(lat), 256'd1);
        xact(1'b1, 1'b0, 32'h0000_0040, 256'd0, 1'b0, lat, rd);
        check("lat1_rd_lat", 256'(lat), 256'd1);
        check("lat1_rd_data", rd, {32{8'h5A}});
        @(negedge clk);
        check("lat1_ack_low", {255'b0, ack1}, 256'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
